// File: rtl/handshake_rr_arbiter_if.sv
// Handshake bundle for handshake_rr_arbiter.
// Three upstream ready/valid requesters (req_0..req_2) share one downstream
// ready/valid channel (out_*). out_id carries the index of the winning requester.
//   modport slave  : arbiter side (takes requests, drives the output channel)
//   modport master : environment side (requesters plus downstream sink)
interface handshake_rr_arbiter_if #(
    parameter int WIDTH = 5
);
    logic             req_0_valid;
    logic             req_0_ready;
    logic [WIDTH-1:0] req_0_data;
    logic             req_1_valid;
    logic             req_1_ready;
    logic [WIDTH-1:0] req_1_data;
    logic             req_2_valid;
    logic             req_2_ready;
    logic [WIDTH-1:0] req_2_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_id;

    modport slave (
        input  req_0_valid, req_0_data, req_1_valid, req_1_data,
               req_2_valid, req_2_data, out_ready,
        output req_0_ready, req_1_ready, req_2_ready,
               out_valid, out_data, out_id
    );

    modport master (
        output req_0_valid, req_0_data, req_1_valid, req_1_data,
               req_2_valid, req_2_data, out_ready,
        input  req_0_ready, req_1_ready, req_2_ready,
               out_valid, out_data, out_id
    );
endinterface

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter with optional burst lock, feeding one registered
// output stage. It grants at most one requester per cycle; the winner's
// payload and index appear on the output one cycle after the handshake.
// Ports:
//   CLK          rising-edge clock
//   ASYNCRESETN  asynchronous active-low reset
//   hs           handshake bundle (slave side): req_0..2 in, out_* out
//   rr_ptr       current highest-priority requester index (debug/monitor)
module handshake_rr_arbiter #(
    parameter int WIDTH = 5,
    parameter int BURST = 1
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESETN,
    handshake_rr_arbiter_if.slave  hs,
    output logic [1:0]             rr_ptr
);
    localparam logic [3:0] BURST_CNT = 4'(BURST);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [1:0]       out_id_q;
    logic [1:0]       rr_ptr_q;
    logic [3:0]       burst_cnt;
    logic             lock_valid;
    logic [1:0]       lock_id;
    // Clears asynchronously with reset and sets on the first clock after
    // release, so no ready can be raised while reset is asserted.
    logic             run_q;

    logic [2:0]       valids;
    logic             can_load;
    logic             lock_hold;
    logic             lock_drop;
    logic [1:0]       scan_base;
    logic [1:0]       scan_1;
    logic [1:0]       scan_2;
    logic             sel_any;
    logic [1:0]       sel_id;
    logic [WIDTH-1:0] sel_data;
    logic             fire;
    logic [3:0]       cnt_next;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign valids   = {hs.req_2_valid, hs.req_1_valid, hs.req_0_valid};
    assign can_load = ~out_valid_q | hs.out_ready;

    assign lock_hold = lock_valid & valids[lock_id];
    // A lock on a requester that went idle is released as soon as the output
    // could take a new transfer; the scan then starts just past it.
    assign lock_drop = lock_valid & ~valids[lock_id] & can_load;
    assign scan_base = lock_drop ? inc3(lock_id) : rr_ptr_q;
    assign scan_1    = inc3(scan_base);
    assign scan_2    = inc3(scan_1);

    always_comb begin
        sel_any = 1'b1;
        sel_id  = scan_base;
        if (lock_hold) begin
            sel_id = lock_id;
        end else if (valids[scan_base]) begin
            sel_id = scan_base;
        end else if (valids[scan_1]) begin
            sel_id = scan_1;
        end else if (valids[scan_2]) begin
            sel_id = scan_2;
        end else begin
            sel_any = 1'b0;
        end
    end

    always_comb begin
        sel_data = '0;
        case (sel_id)
            2'd0:    sel_data = hs.req_0_data;
            2'd1:    sel_data = hs.req_1_data;
            2'd2:    sel_data = hs.req_2_data;
            default: sel_data = '0;
        endcase
    end

    assign fire = run_q & sel_any & can_load;

    assign hs.req_0_ready = fire & (sel_id == 2'd0);
    assign hs.req_1_ready = fire & (sel_id == 2'd1);
    assign hs.req_2_ready = fire & (sel_id == 2'd2);

    assign cnt_next = (lock_valid && lock_id == sel_id) ? burst_cnt + 4'd1 : 4'd1;

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 2'd0;
            rr_ptr_q    <= 2'd0;
            burst_cnt   <= 4'd0;
            lock_valid  <= 1'b0;
            lock_id     <= 2'd0;
            run_q       <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (can_load) begin
                out_valid_q <= fire;
                if (fire) begin
                    out_data_q <= sel_data;
                    out_id_q   <= sel_id;
                end
            end
            if (fire) begin
                if (cnt_next == BURST_CNT) begin
                    lock_valid <= 1'b0;
                    burst_cnt  <= 4'd0;
                    rr_ptr_q   <= inc3(sel_id);
                end else begin
                    lock_valid <= 1'b1;
                    lock_id    <= sel_id;
                    burst_cnt  <= cnt_next;
                    rr_ptr_q   <= scan_base;
                end
            end else if (lock_drop) begin
                lock_valid <= 1'b0;
                burst_cnt  <= 4'd0;
                rr_ptr_q   <= scan_base;
            end
        end
    end

    assign hs.out_valid = out_valid_q;
    assign hs.out_data  = out_data_q;
    assign hs.out_id    = out_id_q;
    assign rr_ptr       = rr_ptr_q;
endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed bench for handshake_rr_arbiter: one instance with BURST=1 and
// one with BURST=3, sharing clock and reset.
module tb_handshake_rr_arbiter;
    logic       CLK = 1'b0;
    logic       ASYNCRESETN = 1'b0;
    logic [1:0] rr_ptr_a;
    logic [1:0] rr_ptr_b;
    int         vectors = 0;
    int         miscompares = 0;

    handshake_rr_arbiter_if #(.WIDTH(5)) ifa ();
    handshake_rr_arbiter_if #(.WIDTH(5)) ifb ();

    handshake_rr_arbiter #(.WIDTH(5), .BURST(1)) dut_a (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .hs(ifa.slave), .rr_ptr(rr_ptr_a)
    );
    handshake_rr_arbiter #(.WIDTH(5), .BURST(3)) dut_b (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .hs(ifb.slave), .rr_ptr(rr_ptr_b)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        {ifa.req_0_valid, ifa.req_1_valid, ifa.req_2_valid, ifa.out_ready} = '0;
        {ifb.req_0_valid, ifb.req_1_valid, ifb.req_2_valid, ifb.out_ready} = '0;
        ifa.req_0_data = '0; ifa.req_1_data = '0; ifa.req_2_data = '0;
        ifb.req_0_data = '0; ifb.req_1_data = '0; ifb.req_2_data = '0;

        // 1. reset and idle
        tick(); tick();
        chk("rst_out_valid", 32'(ifa.out_valid), 0);
        chk("rst_rr_ptr", 32'(rr_ptr_a), 0);
        chk("rst_out_id", 32'(ifa.out_id), 0);
        ASYNCRESETN = 1'b1;
        tick();
        ifa.req_0_valid = 1'b1; ifa.req_0_data = 5'h0A;
        #1;
        chk("t1_ready0", 32'(ifa.req_0_ready), 1);
        tick();
        chk("t1_load_valid", 32'(ifa.out_valid), 1);
        chk("t1_load_data", 32'(ifa.out_data), 32'h0A);
        chk("t1_rr_ptr", 32'(rr_ptr_a), 1);
        ifa.req_0_valid = 1'b0;
        ifa.req_1_valid = 1'b1;
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        chk("t1_async_valid", 32'(ifa.out_valid), 0);
        chk("t1_async_rr", 32'(rr_ptr_a), 0);
        chk("t1_async_ready", 32'({ifa.req_0_ready, ifa.req_1_ready, ifa.req_2_ready}), 0);
        tick();
        ASYNCRESETN = 1'b1;
        ifa.req_1_valid = 1'b0;
        tick(); tick();
        chk("t1_idle_valid", 32'(ifa.out_valid), 0);

        // 2. round-robin fairness, BURST=1
        ifa.out_ready = 1'b1;
        ifa.req_0_data = 5'h01; ifa.req_1_data = 5'h02; ifa.req_2_data = 5'h03;
        ifa.req_0_valid = 1'b1; ifa.req_1_valid = 1'b1; ifa.req_2_valid = 1'b1;
        #1;
        chk("t2_first_ready", 32'({ifa.req_2_ready, ifa.req_1_ready, ifa.req_0_ready}), 32'b001);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t2_id", 32'(ifa.out_id), 32'(k % 3));
            chk("t2_data", 32'(ifa.out_data), 32'(k % 3 + 1));
        end
        ifa.req_0_valid = 1'b0; ifa.req_1_valid = 1'b0; ifa.req_2_valid = 1'b0;
        tick();
        chk("t2_drain_valid", 32'(ifa.out_valid), 0);
        chk("t2_rr_ptr", 32'(rr_ptr_a), 0);

        // 3. backpressure
        ifa.out_ready = 1'b0;
        ifa.req_1_valid = 1'b1; ifa.req_1_data = 5'h15;
        tick();
        ifa.req_1_data = 5'h16;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_hold_valid", 32'(ifa.out_valid), 1);
            chk("t3_hold_data", 32'(ifa.out_data), 32'h15);
            chk("t3_hold_id", 32'(ifa.out_id), 1);
            chk("t3_stall_ready", 32'(ifa.req_1_ready), 0);
            tick();
        end
        ifa.out_ready = 1'b1;
        #1;
        chk("t3_release_ready", 32'(ifa.req_1_ready), 1);
        tick();
        chk("t3_next_data", 32'(ifa.out_data), 32'h16);
        chk("t3_rr_ptr", 32'(rr_ptr_a), 2);
        ifa.req_1_valid = 1'b0;
        tick();
        chk("t3_drained", 32'(ifa.out_valid), 0);

        // 4. pointer wrap from rr_ptr=2
        ifa.req_0_valid = 1'b1; ifa.req_0_data = 5'h07;
        ifa.req_2_valid = 1'b1; ifa.req_2_data = 5'h1C;
        #1;
        chk("t4_ready", 32'({ifa.req_2_ready, ifa.req_1_ready, ifa.req_0_ready}), 32'b100);
        tick();
        chk("t4_first_id", 32'(ifa.out_id), 2);
        chk("t4_first_data", 32'(ifa.out_data), 32'h1C);
        chk("t4_wrap_rr", 32'(rr_ptr_a), 0);
        ifa.req_2_valid = 1'b0;
        tick();
        chk("t4_second_id", 32'(ifa.out_id), 0);
        chk("t4_second_data", 32'(ifa.out_data), 32'h07);
        chk("t4_rr_after", 32'(rr_ptr_a), 1);

        // 6. simultaneous drain and load (out_valid=1 with id 0 here)
        ifa.req_0_valid = 1'b0;
        ifa.req_2_valid = 1'b1; ifa.req_2_data = 5'h1F;
        #1;
        chk("t6_ready2", 32'(ifa.req_2_ready), 1);
        tick();
        chk("t6_valid", 32'(ifa.out_valid), 1);
        chk("t6_data", 32'(ifa.out_data), 32'h1F);
        chk("t6_id", 32'(ifa.out_id), 2);
        ifa.req_2_valid = 1'b0;
        tick();
        chk("t6_drained", 32'(ifa.out_valid), 0);

        // 5. burst lock, BURST=3
        ifb.out_ready = 1'b1;
        ifb.req_0_data = 5'h01; ifb.req_1_data = 5'h02; ifb.req_2_data = 5'h03;
        ifb.req_0_valid = 1'b1; ifb.req_1_valid = 1'b1; ifb.req_2_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t5_id", 32'(ifb.out_id), 32'((k / 3) % 3));
            chk("t5_rr", 32'(rr_ptr_b),
                (k % 3 == 2) ? 32'(((k / 3) + 1) % 3) : 32'((k / 3) % 3));
        end
        tick();
        chk("t5_second_grant0", 32'(ifb.out_id), 0);
        ifb.req_0_valid = 1'b0;
        #1;
        chk("t5_release_ready", 32'({ifb.req_2_ready, ifb.req_1_ready, ifb.req_0_ready}), 32'b010);
        tick();
        chk("t5_release_id", 32'(ifb.out_id), 1);
        chk("t5_release_rr", 32'(rr_ptr_b), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/handshake_rr_arbiter.md
Name: handshake_rr_arbiter

Overview:
- Shares one downstream ready/valid channel between three upstream ready/valid requesters (handshake_arr_0..2) using round-robin arbitration with an optional burst lock.
- Winner data goes into a single registered output stage that carries the data and the winner's index.
- Sits in front of the datapath block whose single `handshake` port carries 5-bit payloads.
- The block is the sole driver of that port's valid and data.

Parameters:
- WIDTH, 5: payload width of each requester and of the output.
- BURST, 1: maximum number of back-to-back transfers one requester may win before the grant must rotate. Legal range 1..15; BURST=1 is pure round-robin.

Ports:
- CLK  input  1  rising-edge clock.
- ASYNCRESETN  input  1  asynchronous, active-low reset.
- req_0_valid  input  1  requester 0 valid.
- req_0_ready  output  1  requester 0 ready.
- req_0_data  input  WIDTH  requester 0 payload.
- req_1_valid / req_1_ready / req_1_data  as requester 0.
- req_2_valid / req_2_ready / req_2_data  as requester 0.
- out_valid  output  1  output stage holds a transfer.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  payload of the held transfer.
- out_id  output  2  index (0..2) of the requester that produced out_data.
- rr_ptr  output  2  current highest-priority requester index, for debug and monitors.

Behaviour:
- Reset (ASYNCRESETN=0, takes effect immediately, independent of CLK):
  - out_valid=0, out_data=0, out_id=0.
  - rr_ptr=0, burst_cnt=0, lock_valid=0.
  - All req_i_ready=0 while reset is asserted.
- Acceptance and ready:
  - can_load = ~out_valid | out_ready.
  - Exactly one requester is selected combinationally each cycle: grant = sel & can_load.
  - req_i_ready = grant[i]. It is combinational from out_valid, out_ready, all req valids and state.
  - It must not depend on req_i_data.
- Selection order:
  - If lock_valid=1 and req_{lock_id}_valid=1, select lock_id.
  - Otherwise select the first valid requester scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - No requester valid: no selection.
- Transfer when req_i_valid & req_i_ready:
  - Next cycle: out_valid=1, out_data=req_i_data, out_id=i.
  - Latency is exactly 1 cycle.
  - Throughput is 1 transfer/cycle when out_ready is held high.
- Output hold:
  - While out_valid=1 and out_ready=0, out_data and out_id are stable and no requester sees ready.
  - Simultaneous drain and load (out_valid & out_ready & new transfer): the output register is overwritten with the new transfer. No bubble is inserted.
  - Drain with no new transfer: out_valid goes to 0 next cycle.
- Burst counter, on each transfer from i:
  - If lock_valid & lock_id==i: burst_cnt+1.
  - Otherwise: burst_cnt=1.
  - If the resulting count reaches BURST: lock_valid=0, burst_cnt=0, rr_ptr=(i+1) mod 3.
  - Otherwise: lock_valid=1, lock_id=i, rr_ptr unchanged.
  - BURST=1 therefore gives strict round-robin: rr_ptr advances to winner+1 on every transfer.
- Lock release:
  - If the locked requester drops valid in a cycle where can_load=1, lock_valid clears.
  - In the same cycle, rr_ptr becomes lock_id+1 and arbitration proceeds normally among the other requesters.
  - A lock is never held for an idle requester.
- Rotation arithmetic: rr_ptr is mod 3; value 3 is never produced. Wrap is 2 → 0.
- Requester protocol:
  - Requesters must hold valid and data until accepted.
  - The arbiter only guarantees that exactly one req_ready is high per cycle at most.
- Reset mid-transfer: any held output is discarded (out_valid=0 asynchronously), and the lock and rr_ptr are cleared.
- Invariants (to be checked by SVA in a bound monitor):
  - At most one req_i_ready is high.
  - out_data and out_id are stable while out_valid & ~out_ready.
  - out_id is never 3.

Test Plan:
1. Reset then idle:
   - Stimulus: ASYNCRESETN low mid-cycle with out_valid=1.
   - Response: out_valid=0 immediately, rr_ptr=0, all readies 0. After release with no valids, out_valid stays 0.
2. Round-robin fairness (BURST=1):
   - Stimulus: all three valid continuously, data 0x01/0x02/0x03, out_ready=1.
   - Response: out_id sequence 0,1,2,0,1,2…, out_data 0x01,0x02,0x03,… starting one cycle after first ready.
3. Backpressure:
   - Stimulus: req_1 only, data 0x15, out_ready=0 for 4 cycles, then 1.
   - Response: out_valid=1 with out_data=0x15 and out_id=1 stable for all 4 cycles; req_1_ready=0 during the stall; then drained.
4. Pointer wrap:
   - Stimulus: rr_ptr=2 via prior grant to 1; then req_0 and req_2 valid.
   - Response: 2 wins first, rr_ptr→0, then 0 wins.
5. Burst lock (BURST=3):
   - Stimulus: all valid, out_ready=1.
   - Response: out_id 0,0,0,1,1,1,2,2,2,0…
   - Second stimulus: req_0 drops valid after 2 grants.
   - Second response: lock releases, next winner 1, rr_ptr=1.
6. Simultaneous drain and load:
   - Stimulus: out_valid=1, out_ready=1, req_2 valid with data 0x1F in the same cycle.
   - Response: next cycle out_valid=1, out_data=0x1F, out_id=2, with no empty cycle.
